seg_scan_receiver: RTL and testbench

// - Receive end of the multiplexed 4-digit 7-segment bus (seg/line/dp) that the stopwatch drives.
// - Samples the bus, waits for each line to settle, and decodes each segment pattern back to BCD.
// - Assembles all four digits into a frame and reports it with a one-cycle valid pulse.
// - Used as the on-chip self-test monitor for the display path.

---
 rtl/seg_scan_receiver.sv | 194 +++++++++++++++++++
 tb/tb_seg_scan_receiver.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_receiver.sv
// seg_scan_receiver: rebuilds a 4-digit BCD frame from the multiplexed active-low seg/line/dp bus.
// Latency: a slot is captured 2+STABLE_CYC cycles after a bus change; the frame appears 1 cycle after the 4th slot.
// Backpressure: none; this is a passive monitor, and frame_valid/timeout are single-cycle pulses with no ready.
// Ports: clk0, reset_sw_n (async, active-low); seg[6:0] {g..a}, line[3:0], dp in (all active-low);
//        digits[15:0] {d3,d2,d1,d0}, dp_out[3:0], seg_err[3:0], frame_valid, stale, timeout out.
module seg_scan_receiver #(
  parameter int STABLE_CYC    = 4,
  parameter int FRAME_TIMEOUT = 1_000_000
) (
  input  logic        clk0,
  input  logic        reset_sw_n,
  input  logic [6:0]  seg,
  input  logic [3:0]  line,
  input  logic        dp,
  output logic [15:0] digits,
  output logic [3:0]  dp_out,
  output logic [3:0]  seg_err,
  output logic        frame_valid,
  output logic        stale,
  output logic        timeout
);
  localparam int            SW       = $clog2(STABLE_CYC + 1);
  localparam logic [SW-1:0] STB_LAST = SW'(STABLE_CYC - 1);
  localparam logic [19:0]   TMO_LAST = 20'(FRAME_TIMEOUT - 1);

  typedef enum logic {S_SETTLE, S_HELD} state_t;

  state_t        state_q, state_d;
  logic [11:0]   sync1_q, sync1_d, sync2_q, sync2_d, w_prev_q, w_prev_d;
  logic [SW-1:0] stab_q, stab_d;
  logic [3:0]    seen_q, seen_d;
  logic [19:0]   tmo_q, tmo_d;
  logic [15:0]   slot_dig_q, slot_dig_d;
  logic [3:0]    slot_dp_q, slot_dp_d, slot_err_q, slot_err_d;
  logic [15:0]   digits_q, digits_d;
  logic [3:0]    dp_out_q, dp_out_d, seg_err_q, seg_err_d;
  logic          frame_valid_q, frame_valid_d;
  logic          stale_q, stale_d, timeout_q, timeout_d;

  logic [3:0] line_act;
  logic [6:0] seg_lit;
  logic       line_ok, w_same, capture, frame_fire, tmo_fire;
  logic [3:0] dec_dig;
  logic       dec_err;

  // Synced bus word layout is {line[3:0], seg[6:0], dp}.
  always_comb begin
    line_act = ~sync2_q[11:8];
    seg_lit  = ~sync2_q[7:1];
    // exactly one line driven low
    line_ok  = (line_act != 4'd0) && ((line_act & (line_act - 4'd1)) == 4'd0);
    w_same   = (sync2_q == w_prev_q);
  end

  always_comb begin
    dec_dig = 4'hE;
    dec_err = 1'b0;
    case (seg_lit)
      7'h3F:        dec_dig = 4'd0;
      7'h06:        dec_dig = 4'd1;
      7'h5B:        dec_dig = 4'd2;
      7'h4F:        dec_dig = 4'd3;
      7'h66:        dec_dig = 4'd4;
      7'h6D:        dec_dig = 4'd5;
      7'h7D:        dec_dig = 4'd6;
      7'h07, 7'h27: dec_dig = 4'd7;   // both common renderings of 7
      7'h7F:        dec_dig = 4'd8;
      7'h6F:        dec_dig = 4'd9;
      7'h00:        dec_dig = 4'hF;   // blanked digit is legal
      default: begin
        dec_dig = 4'hE;
        dec_err = 1'b1;
      end
    endcase
  end

  always_comb begin
    sync1_d       = {line, seg, dp};
    sync2_d       = sync1_q;
    w_prev_d      = sync2_q;
    state_d       = state_q;
    stab_d        = stab_q;
    seen_d        = seen_q;
    tmo_d         = tmo_q;
    slot_dig_d    = slot_dig_q;
    slot_dp_d     = slot_dp_q;
    slot_err_d    = slot_err_q;
    digits_d      = digits_q;
    dp_out_d      = dp_out_q;
    seg_err_d     = seg_err_q;
    stale_d       = stale_q;
    frame_valid_d = 1'b0;
    timeout_d     = 1'b0;
    capture       = 1'b0;

    if (!w_same) begin
      stab_d = '0;
    end else if (stab_q != STB_LAST) begin
      stab_d = stab_q + SW'(1);
    end

    case (state_q)
      S_SETTLE: begin
        if (w_same && (stab_q == STB_LAST) && line_ok) begin
          capture = 1'b1;
          state_d = S_HELD;
        end
      end
      S_HELD: begin
        // one capture per stable period: wait for the bus to move again
        if (!w_same) state_d = S_SETTLE;
      end
      default: state_d = S_SETTLE;
    endcase

    // Frame completion outranks a coincident timeout.
    frame_fire = (seen_q == 4'hF);
    tmo_fire   = !frame_fire && (tmo_q == TMO_LAST);

    if (frame_fire) begin
      digits_d      = slot_dig_q;
      dp_out_d      = slot_dp_q;
      seg_err_d     = slot_err_q;
      frame_valid_d = 1'b1;
      stale_d       = 1'b0;
      seen_d        = 4'd0;
      tmo_d         = 20'd0;
    end else if (tmo_fire) begin
      timeout_d = 1'b1;
      stale_d   = 1'b1;
      seen_d    = 4'd0;
      tmo_d     = 20'd0;
    end else begin
      tmo_d = tmo_q + 20'd1;
    end

    // A capture landing on a clearing cycle still counts toward the next frame.
    if (capture) begin
      for (int i = 0; i < 4; i++) begin
        if (line_act[i]) begin
          slot_dig_d[i*4 +: 4] = dec_dig;
          slot_dp_d[i]         = ~sync2_q[0];
          slot_err_d[i]        = dec_err;
          seen_d[i]            = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk0 or negedge reset_sw_n) begin
    if (!reset_sw_n) begin
      state_q       <= S_SETTLE;
      sync1_q       <= '1;
      sync2_q       <= '1;
      w_prev_q      <= '1;
      stab_q        <= '0;
      seen_q        <= 4'd0;
      tmo_q         <= 20'd0;
      slot_dig_q    <= 16'hFFFF;
      slot_dp_q     <= 4'd0;
      slot_err_q    <= 4'd0;
      digits_q      <= 16'hFFFF;
      dp_out_q      <= 4'd0;
      seg_err_q     <= 4'd0;
      frame_valid_q <= 1'b0;
      stale_q       <= 1'b1;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      w_prev_q      <= w_prev_d;
      stab_q        <= stab_d;
      seen_q        <= seen_d;
      tmo_q         <= tmo_d;
      slot_dig_q    <= slot_dig_d;
      slot_dp_q     <= slot_dp_d;
      slot_err_q    <= slot_err_d;
      digits_q      <= digits_d;
      dp_out_q      <= dp_out_d;
      seg_err_q     <= seg_err_d;
      frame_valid_q <= frame_valid_d;
      stale_q       <= stale_d;
      timeout_q     <= timeout_d;
    end
  end

  assign digits      = digits_q;
  assign dp_out      = dp_out_q;
  assign seg_err     = seg_err_q;
  assign frame_valid = frame_valid_q;
  assign stale       = stale_q;
  assign timeout     = timeout_q;
endmodule

// File: tb/tb_seg_scan_receiver.sv
// tb_seg_scan_receiver: directed scans plus randomized bus traffic against a run-length based model.
// Latency: the model predicts every output cycle-exactly; compared on each falling edge.
// Backpressure: not applicable; the bench drives the bus freely.
module tb_seg_scan_receiver;
  localparam int STB = 4;
  localparam int FT  = 50;
  localparam logic [6:0] PAT [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                      7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  localparam logic [3:0] LINES [4] = '{4'hE, 4'hD, 4'hB, 4'h7};

  logic        clk0       = 1'b0;
  logic        reset_sw_n = 1'b1;
  logic [6:0]  seg_i      = 7'h7F;
  logic [3:0]  line_i     = 4'hF;
  logic        dp_i       = 1'b1;
  logic [15:0] digits;
  logic [3:0]  dp_out, seg_err;
  logic        frame_valid, stale, timeout;

  seg_scan_receiver #(.STABLE_CYC(STB), .FRAME_TIMEOUT(FT)) dut (
    .clk0(clk0), .reset_sw_n(reset_sw_n), .seg(seg_i), .line(line_i), .dp(dp_i),
    .digits(digits), .dp_out(dp_out), .seg_err(seg_err),
    .frame_valid(frame_valid), .stale(stale), .timeout(timeout)
  );

  always #5 clk0 = ~clk0;

  int n_err = 0, n_chk = 0;
  int cyc = 0, fv_cnt = 0, to_cnt = 0, fv_cyc = 0, to_cyc = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [11:0] m_p1, m_p2, m_last;
  int          m_run, m_tmo;
  logic [3:0]  m_seen, m_dp, m_err;
  logic [3:0]  m_dig [4];
  logic [15:0] e_digits;
  logic [3:0]  e_dp, e_err;
  logic        e_fv, e_stale, e_to;

  // returns {err, digit}
  function automatic logic [4:0] m_decode(input logic [6:0] raw);
    logic [6:0] lit;
    lit = ~raw;
    if (lit == 7'h00) return {1'b0, 4'hF};
    if (lit == 7'h27) return {1'b0, 4'd7};
    for (int d = 0; d < 10; d++) if (lit == PAT[d]) return {1'b0, 4'(d)};
    return {1'b1, 4'hE};
  endfunction

  task automatic model_reset();
    m_p1 = '1; m_p2 = '1; m_last = '1; m_run = 1; m_tmo = 0; m_seen = 0;
    m_dp = 0; m_err = 0;
    for (int k = 0; k < 4; k++) m_dig[k] = 4'hF;
    e_digits = 16'hFFFF; e_dp = 0; e_err = 0; e_fv = 0; e_stale = 1; e_to = 0;
  endtask

  task automatic model_step();
    logic [11:0] w;
    logic [3:0]  act;
    logic [4:0]  dec;
    logic        cap, ff, tf;
    w = m_p2;                      // word the receiver sees after two sync stages
    if (w == m_last) begin
      if (m_run < 1000) m_run++;
    end else begin
      m_run = 1;
    end
    m_last = w;
    m_p2 = m_p1;
    m_p1 = {line_i, seg_i, dp_i};
    act = ~w[11:8];
    // capture once the same word has been seen STB+1 times in a row on a valid line
    cap = (m_run == STB + 1) && ($countones(act) == 1);
    ff  = (m_seen == 4'hF);
    tf  = !ff && (m_tmo == FT - 1);
    e_fv = ff;
    e_to = tf;
    if (ff) begin
      for (int k = 0; k < 4; k++) e_digits[k*4 +: 4] = m_dig[k];
      e_dp = m_dp; e_err = m_err; e_stale = 0; m_seen = 0; m_tmo = 0;
    end else if (tf) begin
      e_stale = 1; m_seen = 0; m_tmo = 0;
    end else begin
      m_tmo++;
    end
    if (cap) begin
      dec = m_decode(w[7:1]);
      for (int k = 0; k < 4; k++) begin
        if (act[k]) begin
          m_dig[k] = dec[3:0]; m_err[k] = dec[4]; m_dp[k] = ~w[0]; m_seen[k] = 1'b1;
        end
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk0 or negedge reset_sw_n);
      if (!reset_sw_n) model_reset();
      else model_step();
    end
  end

  // ---------------- compare process ----------------
  initial begin
    forever begin
      @(negedge clk0);
      cyc++;
      if (frame_valid === 1'b1) begin fv_cnt++; fv_cyc = cyc; end
      if (timeout === 1'b1) begin to_cnt++; to_cyc = cyc; end
      if (chk_en) begin
        check("digits", digits, e_digits);
        check("dp_out", dp_out, e_dp);
        check("seg_err", seg_err, e_err);
        check("frame_valid", frame_valid, e_fv);
        check("stale", stale, e_stale);
        check("timeout", timeout, e_to);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic put(input logic [3:0] l, input logic [6:0] s, input logic d, input int n);
    line_i = l; seg_i = s; dp_i = d;
    repeat (n) @(negedge clk0);
  endtask

  task automatic idle_and_settle(input int n);
    put(4'hF, 7'h7F, 1'b1, n);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk0); #2 reset_sw_n = 1'b0;
    repeat (3) @(posedge clk0);
    #2 reset_sw_n = 1'b1;
  endtask

  logic [3:0] r_line;
  logic [6:0] r_seg;
  int         r_sel, wait_n;

  initial begin
    #2 reset_sw_n = 1'b0;
    chk_en = 1'b1;
    repeat (3) @(posedge clk0);
    #2 reset_sw_n = 1'b1;
    repeat (2) @(negedge clk0);
    #1;
    check("reset_digits", digits, 16'hFFFF);
    check("reset_stale", stale, 1);
    check("reset_no_frame", fv_cnt, 0);

    // clean frame 0,1,2,3 with dp on digit 1
    put(4'hE, 7'h40, 1'b1, 10);
    put(4'hD, 7'h79, 1'b0, 10);
    put(4'hB, 7'h24, 1'b1, 10);
    put(4'h7, 7'h30, 1'b1, 10);
    idle_and_settle(2);
    check("clean_frame_count", fv_cnt, 1);
    check("clean_digits", digits, 16'h3210);
    check("clean_dp", dp_out, 4'b0010);
    check("clean_err", seg_err, 4'b0000);
    check("clean_stale", stale, 0);

    // glitching digit 1 must not be captured; steady value afterwards completes the frame
    put(4'hE, 7'h40, 1'b1, 6);
    put(4'hB, 7'h30, 1'b1, 6);
    put(4'h7, 7'h19, 1'b1, 6);
    for (int g = 0; g < 3; g++) begin
      put(4'hD, 7'h24, 1'b1, 2);
      put(4'hD, 7'h79, 1'b1, 2);
    end
    idle_and_settle(2);
    check("glitch_no_frame", fv_cnt, 1);
    put(4'hD, 7'h24, 1'b1, 6);
    idle_and_settle(2);
    check("glitch_frame_count", fv_cnt, 2);
    check("glitch_digits", digits, 16'h4320);

    // two lines low is ignored; an undecodable pattern flags its slot
    put(4'hC, 7'h24, 1'b1, 6);
    put(4'hE, 7'h7E, 1'b1, 6);
    put(4'hD, 7'h79, 1'b1, 6);
    put(4'hB, 7'h24, 1'b1, 6);
    put(4'h7, 7'h30, 1'b1, 6);
    idle_and_settle(2);
    check("bad_frame_count", fv_cnt, 3);
    check("bad_digits", digits, 16'h321E);
    check("bad_err", seg_err, 4'b0001);

    // incomplete scan -> timeout FT cycles after the last frame
    put(4'hE, 7'h40, 1'b1, 6);
    put(4'hD, 7'h79, 1'b1, 6);
    put(4'hB, 7'h24, 1'b1, 6);
    line_i = 4'hF; seg_i = 7'h7F; dp_i = 1'b1;
    wait_n = 0;
    while (to_cnt == 0 && wait_n < 100) begin
      @(negedge clk0); #1;
      wait_n++;
    end
    check("timeout_seen", to_cnt, 1);
    check("timeout_delay", to_cyc - fv_cyc, FT);
    check("timeout_stale", stale, 1);
    check("timeout_digits_hold", digits, 16'h321E);
    check("timeout_no_frame", fv_cnt, 3);

    // overwrite of slot 0 before completion: latest wins
    put(4'hE, 7'h40, 1'b1, 6);
    put(4'hE, 7'h79, 1'b1, 6);
    put(4'hD, 7'h24, 1'b1, 6);
    put(4'hB, 7'h30, 1'b1, 6);
    put(4'h7, 7'h19, 1'b1, 6);
    idle_and_settle(2);
    check("overwrite_count", fv_cnt, 4);
    check("overwrite_digits", digits, 16'h4321);

    // reset after two slots discards them
    put(4'hE, 7'h40, 1'b1, 6);
    put(4'hD, 7'h24, 1'b1, 6);
    @(posedge clk0); #2 reset_sw_n = 1'b0;
    #1;
    check("midreset_digits", digits, 16'hFFFF);
    check("midreset_stale", stale, 1);
    repeat (3) @(posedge clk0);
    #2 reset_sw_n = 1'b1;
    put(4'hB, 7'h30, 1'b1, 6);
    put(4'h7, 7'h19, 1'b1, 6);
    idle_and_settle(2);
    check("midreset_no_frame", fv_cnt, 4);
    check("midreset_digits_after", digits, 16'hFFFF);

    // randomized traffic, mostly in scan order
    for (int i = 0; i < 400; i++) begin
      r_sel  = $urandom_range(0, 9);
      r_line = (r_sel == 0) ? 4'($urandom_range(0, 15)) : LINES[i % 4];
      r_sel  = $urandom_range(0, 9);
      if (r_sel < 7)       r_seg = ~PAT[$urandom_range(0, 9)];
      else if (r_sel == 7) r_seg = 7'h7F;
      else if (r_sel == 8) r_seg = 7'h58;
      else                 r_seg = 7'($urandom_range(0, 127));
      put(r_line, r_seg, 1'($urandom_range(0, 1)), $urandom_range(1, 9));
      if (i == 200) do_reset();
    end
    idle_and_settle(5);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
